camera_capture: RTL and testbench
=================================

Name: camera_capture

Overview:
- Sink end of the camera pixel stream.
- Drives camera_en for exactly one frame and captures each byte qualified by data_valid into an internal frame buffer.
- Exposes the stored frame to downstream image filters through a 1-cycle-latency random read port.
- Reports completion, overrun and timeout status.

Parameters:
- FRAME_W, 4, pixels per row
- FRAME_H, 3, rows per frame; FRAME_PIXELS = FRAME_W*FRAME_H (12)
- PIX_W, 8, pixel width in bits
- TIMEOUT, 15, maximum cycles without data_valid while capturing before aborting
- ADDR_W, $clog2(FRAME_PIXELS), buffer address width

Ports:
- clk  in  1  clock; all logic on posedge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle capture request
- camera_en  out  1  camera enable, registered
- data_valid  in  1  camera byte qualifier
- data_in  in  PIX_W  camera byte; Z/X tolerated while data_valid=0
- busy  out  1  capture in progress
- frame_done  out  1  one-cycle pulse when a full frame is stored
- frame_ready  out  1  level; buffer holds a complete frame
- overrun  out  1  sticky; unexpected byte discarded
- timeout_err  out  1  sticky; capture aborted
- rd_en  in  1  read request
- rd_addr  in  ADDR_W  raster-order pixel index
- rd_data  out  PIX_W  pixel, valid 1 cycle after rd_en
- rd_valid  out  1  rd_en delayed one cycle

Behaviour:
- Reset (async, rst_n=0): state IDLE; camera_en, busy, frame_done, frame_ready, overrun, timeout_err, rd_valid = 0; rd_data = 0; counters = 0. Buffer contents are not reset.
- States:
  - IDLE: start=1 -> CAPTURE; frame_ready, overrun, timeout_err cleared; issue_cnt, wr_cnt, tmo_cnt cleared.
  - CAPTURE: camera_en=1 for exactly FRAME_PIXELS consecutive cycles, first high cycle = edge after start sampled. When issue_cnt hits FRAME_PIXELS -> DRAIN, camera_en low.
  - DRAIN: camera_en=0; wait until wr_cnt == FRAME_PIXELS -> DONE.
  - DONE: frame_done=1 for one cycle, frame_ready=1 -> IDLE.
- busy=1 in CAPTURE, DRAIN and DONE.
- Write: in CAPTURE/DRAIN, data_valid=1 with wr_cnt<FRAME_PIXELS -> buf[wr_cnt]=data_in; wr_cnt++.
- Camera has 1-cycle registered latency; nominally the first byte arrives one edge after camera_en rises, the last one edge after it falls.
- Overrun: data_valid=1 in IDLE or DONE, or with wr_cnt==FRAME_PIXELS -> byte discarded, overrun=1. Not fatal; frame still completes.
- Timeout: tmo_cnt increments each CAPTURE/DRAIN cycle without data_valid and clears on data_valid. Reaching TIMEOUT -> timeout_err=1, camera_en=0, frame_ready=0, return to IDLE, no frame_done.
- start while busy: ignored. start asserted in the same cycle as frame_done: ignored.
- Read port: always active, including during capture (returns current buffer contents, possibly mixed frames). rd_addr >= FRAME_PIXELS returns 0.
- Reset mid-capture: camera_en drops asynchronously, all status cleared, partial frame not flagged ready.
- Nominal latency: start edge to frame_done = FRAME_PIXELS+2 cycles.

Optional Feature:
- Macro: CAMERA_CAPTURE_CHECKSUM_EN.
- Defined:
  - Adds output checksum [15:0], a modulo-2^16 sum of all accepted (written) bytes of the current frame.
  - Cleared on start and reset; final value stable from the frame_done cycle until the next start.
  - Discarded overrun bytes are excluded.
- Undefined: port and adder absent; all other behaviour identical.

Decomposition:
- Shared package/header camera_pkg:
  - frame geometry defaults (FRAME_W, FRAME_H, PIX_W)
  - FRAME_PIXELS
  - state encodings (IDLE, CAPTURE, DRAIN, DONE)
  - TIMEOUT default
- One sub-module, frame_buffer_ram: single-clock RAM, FRAME_PIXELS x PIX_W, synchronous write, registered read, no reset on storage.

Test Plan:
- Nominal frame with camera model (bytes BC,27,81,FF,CE,1F,E0,A9,38,2B,D4,11), start pulse:
  - camera_en high exactly 12 cycles; frame_done once, 14 cycles after start edge.
  - Reads addr0=BC, addr3=FF, addr11=11, each valid one cycle after rd_en.
  - With macro: checksum=0x0621.
- Back-to-back frames: second start after frame_done -> identical contents, frame_ready low from start until second frame_done, overrun=0.
- Stalled camera: data_valid forced low after 5 bytes -> timeout_err=1 exactly TIMEOUT cycles after the last valid; camera_en=0, frame_ready=0, busy=0, no frame_done.
- Spurious byte: data_valid=1 with data_in=0x55 while IDLE -> overrun=1, buffer unchanged; next start clears overrun.
- start pulsed mid-capture -> ignored; camera_en count stays 12; single frame_done.
- rst_n asserted during cycle 6 of CAPTURE -> camera_en=0 immediately, all status 0; subsequent start completes a normal frame.

Source files
------------

// File: rtl/camera_pkg.sv
// Shared definitions for the camera capture path: frame geometry defaults,
// capture timeout default and the capture FSM state encoding.
// Optional checksum output is enabled by the CAMERA_CAPTURE_CHECKSUM_EN macro.
package camera_pkg;

  localparam int DEF_FRAME_W      = 4;
  localparam int DEF_FRAME_H      = 3;
  localparam int DEF_PIX_W        = 8;
  localparam int DEF_FRAME_PIXELS = DEF_FRAME_W * DEF_FRAME_H;
  localparam int DEF_TIMEOUT      = 15;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DRAIN   = 2'd2,
    DONE    = 2'd3
  } state_t;

endpackage

// File: rtl/frame_buffer_ram.sv
// Single-clock frame store: synchronous write, registered read port.
// Read latency 1 cycle; output updates only when re=1, out-of-range reads give 0.
// No backpressure; storage is not reset, only the read register is.
module frame_buffer_ram #(
  parameter int DEPTH  = 12,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage write; the writer guarantees waddr is in range.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read, holding its value between requests.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      if (int'(raddr) < DEPTH) rdata <= mem[raddr];
      else                     rdata <= '0;
    end
  end

endmodule

// File: rtl/camera_capture.sv
// Camera sink: enables the camera for one frame and stores every valid byte.
// Start edge to frame_done is FRAME_PIXELS+2 cycles; read port latency 1 cycle.
// No backpressure toward the camera; extra bytes are dropped and flagged as overrun.
// Optional CAMERA_CAPTURE_CHECKSUM_EN adds a 16-bit sum of accepted bytes.
module camera_capture
  import camera_pkg::*;
#(
  parameter int FRAME_W      = DEF_FRAME_W,
  parameter int FRAME_H      = DEF_FRAME_H,
  parameter int PIX_W        = DEF_PIX_W,
  parameter int TIMEOUT      = DEF_TIMEOUT,
  parameter int FRAME_PIXELS = FRAME_W * FRAME_H,
  parameter int ADDR_W       = $clog2(FRAME_PIXELS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              camera_en,
  input  logic              data_valid,
  input  logic [PIX_W-1:0]  data_in,
  output logic              busy,
  output logic              frame_done,
  output logic              frame_ready,
  output logic              overrun,
  output logic              timeout_err,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [PIX_W-1:0]  rd_data,
  output logic              rd_valid
`ifdef CAMERA_CAPTURE_CHECKSUM_EN
  ,
  output logic [15:0]       checksum
`endif
);

  localparam int CNT_W = $clog2(FRAME_PIXELS + 1);
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] PIX_LAST = CNT_W'(FRAME_PIXELS - 1);
  localparam logic [CNT_W-1:0] PIX_FULL = CNT_W'(FRAME_PIXELS);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  state_t             state;
  logic [CNT_W-1:0]   issue_cnt;
  logic [CNT_W-1:0]   wr_cnt;
  logic [TMO_W-1:0]   tmo_cnt;
  logic               capturing;
  logic               wr_accept;

  assign capturing = (state == CAPTURE) || (state == DRAIN);
  assign wr_accept = data_valid && capturing && (wr_cnt < PIX_FULL);

  // Capture sequencer: enable window, write count, stall timeout and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      camera_en   <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      frame_ready <= 1'b0;
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
      issue_cnt   <= '0;
      wr_cnt      <= '0;
      tmo_cnt     <= '0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state       <= CAPTURE;
            camera_en   <= 1'b1;
            busy        <= 1'b1;
            frame_ready <= 1'b0;
            overrun     <= 1'b0;
            timeout_err <= 1'b0;
            issue_cnt   <= '0;
            wr_cnt      <= '0;
            tmo_cnt     <= '0;
          end
        end
        CAPTURE, DRAIN: begin
          if (state == CAPTURE) begin
            issue_cnt <= issue_cnt + 1'b1;
            if (issue_cnt == PIX_LAST) begin
              camera_en <= 1'b0;
              state     <= DRAIN;
            end
          end
          if (wr_accept) wr_cnt <= wr_cnt + 1'b1;
          if (data_valid) tmo_cnt <= '0;
          else            tmo_cnt <= tmo_cnt + 1'b1;
          // A completed frame wins over a coincident stall expiry.
          if ((state == DRAIN) && (wr_cnt == PIX_FULL)) begin
            state       <= DONE;
            frame_done  <= 1'b1;
            frame_ready <= 1'b1;
            tmo_cnt     <= '0;
          end else if (!data_valid && (tmo_cnt == TMO_LAST)) begin
            state       <= IDLE;
            camera_en   <= 1'b0;
            busy        <= 1'b0;
            frame_ready <= 1'b0;
            timeout_err <= 1'b1;
            tmo_cnt     <= '0;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
      // Any byte that is not written is dropped; placed last so it wins over the start clear.
      if (data_valid && !wr_accept) overrun <= 1'b1;
    end
  end

  // Read-valid tracks the one-cycle RAM read latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_valid <= 1'b0;
    else        rd_valid <= rd_en;
  end

`ifdef CAMERA_CAPTURE_CHECKSUM_EN
  // Running sum of accepted bytes, restarted by an accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      checksum <= '0;
    end else if ((state == IDLE) && start) begin
      checksum <= '0;
    end else if (wr_accept) begin
      checksum <= checksum + 16'(data_in);
    end
  end
`endif

  frame_buffer_ram #(
    .DEPTH  (FRAME_PIXELS),
    .DATA_W (PIX_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_accept),
    .waddr (wr_cnt[ADDR_W-1:0]),
    .wdata (data_in),
    .re    (rd_en),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

endmodule

// File: tb/tb_camera_capture.sv
// Bench for camera_capture: a registered camera model feeds a fixed frame,
// reads are checked through an expected-value queue, status through check_eq.
// Covers nominal, back-to-back, stall timeout, spurious byte, mid-capture start and reset.
module tb_camera_capture;
  import camera_pkg::*;

  localparam int FP = DEF_FRAME_W * DEF_FRAME_H;
  localparam int AW = $clog2(FP);

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          camera_en;
  logic          data_valid;
  logic [7:0]    data_in;
  logic          busy;
  logic          frame_done;
  logic          frame_ready;
  logic          overrun;
  logic          timeout_err;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data;
  logic          rd_valid;
`ifdef CAMERA_CAPTURE_CHECKSUM_EN
  logic [15:0]   checksum;
`endif

  camera_capture dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .camera_en   (camera_en),
    .data_valid  (data_valid),
    .data_in     (data_in),
    .busy        (busy),
    .frame_done  (frame_done),
    .frame_ready (frame_ready),
    .overrun     (overrun),
    .timeout_err (timeout_err),
    .rd_en       (rd_en),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid)
`ifdef CAMERA_CAPTURE_CHECKSUM_EN
    ,
    .checksum    (checksum)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] pix [FP] = '{8'hBC, 8'h27, 8'h81, 8'hFF, 8'hCE, 8'h1F,
                           8'hE0, 8'hA9, 8'h38, 8'h2B, 8'hD4, 8'h11};
  logic [7:0] sb_q [$];

  int n_chk  = 0;
  int n_pass = 0;

  // Per-frame observations collected by run_frame.
  int   cnt_en, fd_cnt, fd_cyc, tmo_cyc, last_dv_cyc, bytes_sent;
  logic ready_mid, ovr_mid;
  logic [15:0] exp_sum;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Issue one read; the expected pixel is queued now and checked when rd_valid comes back.
  task automatic read_px(input int a);
    logic [7:0] e;
    e = 8'h00;
    if (a < FP) e = pix[a];
    sb_q.push_back(e);
    rd_addr = AW'(a);
    rd_en   = 1'b1;
    @(posedge clk); #1;
    rd_en = 1'b0;
    check_eq($sformatf("rd_valid[%0d]", a), rd_valid, 1);
    if (rd_valid && sb_q.size() > 0) check_eq($sformatf("rd_data[%0d]", a), rd_data, sb_q.pop_front());
  endtask

  task automatic observe(input int c);
    if (camera_en) cnt_en++;
    if (frame_done) begin fd_cnt++; fd_cyc = c; end
    if (timeout_err && tmo_cyc < 0) tmo_cyc = c;
    if (c == 1) ovr_mid = overrun;
    if (c == 5) ready_mid = frame_ready;
  endtask

  // Start pulse, then a fixed window of cycles with the camera answering camera_en one cycle late.
  // limit = bytes the camera delivers; mid_start = cycle of an extra start pulse (-1 for none).
  task automatic run_frame(input int limit, input int mid_start);
    logic en_q, dv_prev;
    cnt_en = 0; fd_cnt = 0; fd_cyc = -1; tmo_cyc = -1; last_dv_cyc = -1; bytes_sent = 0;
    exp_sum = 16'h0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    observe(0);
    for (int c = 1; c <= 30; c++) begin
      en_q    = camera_en;
      dv_prev = data_valid;
      start   = (c == mid_start);
      @(posedge clk); #1;
      start = 1'b0;
      if (dv_prev) last_dv_cyc = c;
      data_valid = en_q && (bytes_sent < limit);
      data_in    = data_valid ? pix[bytes_sent] : 8'h00;
      if (data_valid) begin
        exp_sum = exp_sum + 16'(pix[bytes_sent]);
        bytes_sent++;
      end
      observe(c);
    end
    data_valid = 1'b0;
  endtask

  task automatic check_nominal(input string t);
    check_eq({t, ".cam_en_cycles"}, cnt_en, FP);
    check_eq({t, ".frame_done_cnt"}, fd_cnt, 1);
    check_eq({t, ".frame_done_lat"}, fd_cyc, FP + 2);
    check_eq({t, ".frame_ready"}, frame_ready, 1);
    check_eq({t, ".busy_end"}, busy, 0);
    check_eq({t, ".timeout_err"}, timeout_err, 0);
`ifdef CAMERA_CAPTURE_CHECKSUM_EN
    check_eq({t, ".checksum"}, checksum, exp_sum);
`endif
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; data_valid = 1'b0; data_in = 8'h00;
    rd_en = 1'b0; rd_addr = '0;
    #12;
    check_eq("reset.status", {camera_en, busy, frame_done, frame_ready, overrun, timeout_err, rd_valid}, 0);
    check_eq("reset.rd_data", rd_data, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Nominal frame.
    run_frame(FP, -1);
    check_nominal("nominal");
    check_eq("nominal.overrun", overrun, 0);
`ifdef CAMERA_CAPTURE_CHECKSUM_EN
    check_eq("nominal.checksum_abs", checksum, 16'h0621);
`endif
    read_px(0); read_px(3); read_px(11); read_px(12); read_px(15);

    // Back-to-back frame.
    run_frame(FP, -1);
    check_nominal("b2b");
    check_eq("b2b.ready_during", ready_mid, 0);
    check_eq("b2b.overrun", overrun, 0);
    for (int a = 0; a < FP; a++) read_px(a);

    // Camera stalls after 5 bytes.
    run_frame(5, -1);
    check_eq("stall.last_valid_cyc", last_dv_cyc, 6);
    check_eq("stall.timeout_cyc", tmo_cyc, last_dv_cyc + DEF_TIMEOUT);
    check_eq("stall.timeout_err", timeout_err, 1);
    check_eq("stall.camera_en", camera_en, 0);
    check_eq("stall.frame_ready", frame_ready, 0);
    check_eq("stall.busy", busy, 0);
    check_eq("stall.frame_done_cnt", fd_cnt, 0);

    // Spurious byte while idle.
    data_valid = 1'b1; data_in = 8'h55;
    @(posedge clk); #1;
    data_valid = 1'b0; data_in = 8'h00;
    check_eq("spur.overrun", overrun, 1);
    read_px(0); read_px(7);
    run_frame(FP, -1);
    check_eq("spur.overrun_cleared", ovr_mid, 0);
    check_nominal("spur_next");
    check_eq("spur_next.overrun", overrun, 0);

    // Extra start mid-capture is ignored.
    run_frame(FP, 4);
    check_nominal("midstart");

    // Reset during capture cycle 6.
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    check_eq("rst.camera_en_before", camera_en, 1);
    rst_n = 1'b0;
    #1;
    check_eq("rst.camera_en", camera_en, 0);
    check_eq("rst.status", {busy, frame_done, frame_ready, overrun, timeout_err, rd_valid}, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    run_frame(FP, -1);
    check_nominal("after_rst");
    read_px(11);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
